ofdm_qpsk_deinterleaver: RTL

Block deinterleaver sitting directly downstream of the receiver's QPSK demapper. It consumes one 2-bit demapped symbol per data subcarrier (the `sym` / `valid_final` stream of the receiver top). It undoes the 802.11a per-OFDM-symbol bit interleaver (N_BPSC=2, so s=1). It emits bit pairs in original coded order through a valid/ready interface for the downstream rate-1/2 Viterbi decoder. Ping-pong buffering lets one OFDM symbol be written while the previous one is read.

---
 rtl/ofdm_qpsk_deinterleaver_if.sv | 34 +++
 rtl/ofdm_qpsk_deinterleaver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ofdm_qpsk_deinterleaver_if.sv
// Symbol-in / bit-pair-out bus of the QPSK deinterleaver.
// The slave modport is the deinterleaver side; the master modport drives it.
interface ofdm_qpsk_deinterleaver_if;
    logic       frame_start;
    logic       sym_en;
    logic [1:0] sym;
    logic       dout_ready;
    logic       dout_valid;
    logic [1:0] dout;
    logic       dout_last;
    logic       overflow;

    modport master (
        output frame_start,
        output sym_en,
        output sym,
        output dout_ready,
        input  dout_valid,
        input  dout,
        input  dout_last,
        input  overflow
    );

    modport slave (
        input  frame_start,
        input  sym_en,
        input  sym,
        input  dout_ready,
        output dout_valid,
        output dout,
        output dout_last,
        output overflow
    );
endinterface

// File: rtl/ofdm_qpsk_deinterleaver.sv
// Ping-pong block deinterleaver for 802.11a QPSK (N_BPSC=2): writes received bits at their
// permuted address, reads bit pairs back in coded order over a valid/ready handshake.
module ofdm_qpsk_deinterleaver #(
    parameter int unsigned NSC = 48
) (
    input logic                         clock,
    input logic                         reset,
    ofdm_qpsk_deinterleaver_if.slave    bus
);

    localparam int unsigned NCBPS = 2 * NSC;
    localparam int unsigned AW    = $clog2(NCBPS);
    localparam int unsigned CW    = $clog2(NSC);
    localparam logic [CW-1:0] LastCnt = CW'(NSC - 1);

    // Received bit j lands at coded position k; division is by a constant.
    function automatic logic [AW-1:0] perm_addr(input logic [AW-1:0] j);
        int unsigned jj;
        int unsigned k;
        jj = {{(32 - AW){1'b0}}, j};
        k  = 16 * jj - (NCBPS - 1) * ((16 * jj) / NCBPS);
        return AW'(k);
    endfunction

    logic [NCBPS-1:0] bank_q [2];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;

    logic          wr_bank_b;
    logic          rd_bank_b;
    logic [CW-1:0] wr_cnt_b;
    logic [CW-1:0] rd_cnt_b;
    logic [1:0]    full_b;
    logic          wr_fire;
    logic          rd_fire;
    logic          drop;
    logic          dout_valid;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [AW-1:0] rd_addr0, rd_addr1;

    // frame_start replaces the current pointers before the same-cycle write is applied.
    always_comb begin
        wr_bank_b = bus.frame_start ? 1'b0 : wr_bank_q;
        rd_bank_b = bus.frame_start ? 1'b0 : rd_bank_q;
        wr_cnt_b  = bus.frame_start ? '0 : wr_cnt_q;
        rd_cnt_b  = bus.frame_start ? '0 : rd_cnt_q;
        full_b    = bus.frame_start ? 2'b00 : full_q;
    end

    assign dout_valid = full_q[rd_bank_q];
    assign wr_fire    = bus.sym_en & ~full_b[wr_bank_b];
    assign drop       = bus.sym_en & full_b[wr_bank_b];
    assign rd_fire    = dout_valid & bus.dout_ready & ~bus.frame_start;

    assign wr_addr0 = perm_addr({wr_cnt_b, 1'b0});
    assign wr_addr1 = perm_addr({wr_cnt_b, 1'b1});
    assign rd_addr0 = {rd_cnt_q, 1'b0};
    assign rd_addr1 = {rd_cnt_q, 1'b1};

    always_comb begin
        wr_bank_d  = wr_bank_b;
        wr_cnt_d   = wr_cnt_b;
        rd_bank_d  = rd_bank_b;
        rd_cnt_d   = rd_cnt_b;
        full_d     = full_b;
        overflow_d = overflow_q | drop;

        if (wr_fire) begin
            if (wr_cnt_b == LastCnt) begin
                full_d[wr_bank_b] = 1'b1;
                wr_bank_d         = ~wr_bank_b;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_b + CW'(1);
            end
        end

        // A full read bank and a non-full write bank are never the same bank.
        if (rd_fire) begin
            if (rd_cnt_q == LastCnt) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank storage carries no reset; the full flags gate every read.
    always_ff @(posedge clock) begin
        if (reset && wr_fire) begin
            bank_q[wr_bank_b][wr_addr0] <= bus.sym[1];
            bank_q[wr_bank_b][wr_addr1] <= bus.sym[0];
        end
    end

    assign bus.dout_valid = dout_valid;
    assign bus.dout       = dout_valid ? {bank_q[rd_bank_q][rd_addr0], bank_q[rd_bank_q][rd_addr1]}
                                       : 2'b00;
    assign bus.dout_last  = dout_valid & (rd_cnt_q == LastCnt);
    assign bus.overflow   = overflow_q;

endmodule
